// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, source indices
// and the broadcast bus word seen by reservation stations, RST and ROB.
package cdb_pkg;
    localparam int CDB_DATA_W  = 40;
    localparam int CDB_NUM_SRC = 5;

    localparam int SRC_ALU = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;
    localparam int SRC_LS  = 3;
    localparam int SRC_BR  = 4;

    typedef struct packed {
        logic                  valid;
        logic [CDB_DATA_W-1:0] payload;
    } cdb_word_t;
endpackage

// File: rtl/cdb_arbiter_rr_if.sv
// Request/grant/broadcast bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_rr_if import cdb_pkg::*; #(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int DATA_W  = CDB_DATA_W
) ();
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]        req;
    logic [NUM_SRC*DATA_W-1:0] data_in;
    logic [NUM_SRC-1:0]        grant;
    logic                      cdb_valid;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;

    modport master (output req, data_in, input grant, cdb_valid, cdb_data, cdb_src);
    modport slave  (input req, data_in, output grant, cdb_valid, cdb_data, cdb_src);
endinterface

// File: rtl/cdb_arbiter_rr_rr_pick.sv
// Rotate-and-find-first picker: first requester at or after ptr, wrapping.
// Tie ptr to zero for plain lowest-index priority.
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt2;

    always_comb begin
        // rot[j] is req[(ptr+j) mod N]; isolating its lowest bit and rotating
        // back gives the winner in original index space.
        rot     = N'({req, req} >> ptr);
        rot_gnt = rot & (-rot);
        gnt2    = {{N{1'b0}}, rot_gnt} << ptr;
        grant   = gnt2[N-1:0] | gnt2[2*N-1:N];
    end
endmodule

// File: rtl/cdb_arbiter_rr.sv
// CDB arbiter: one-hot combinational grant, registered one-per-cycle broadcast.
// Define CDB_STARVE_GUARD_EN to add per-source wait counters that override policy.
module cdb_arbiter_rr import cdb_pkg::*; #(
    parameter int NUM_SRC  = CDB_NUM_SRC,
    parameter int DATA_W   = CDB_DATA_W,
    parameter int RR_MODE  = 1,
    parameter int MAX_WAIT = 8
) (
    input logic            clk,
    input logic            rst,
    cdb_arbiter_rr_if.slave bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    generate
        if (NUM_SRC < 2 || MAX_WAIT < 1) begin : g_bad_cfg
            $error("cdb_arbiter_rr: NUM_SRC must be >= 2 and MAX_WAIT >= 1");
        end
    endgenerate

    logic [SRC_W-1:0]   ptr, pick_ptr, gidx;
    logic [NUM_SRC-1:0] pol_grant, grant_raw, grant;
    logic [DATA_W-1:0]  gdata;
    logic               any_grant;
    logic               valid_q;
    logic [DATA_W-1:0]  data_q;
    logic [SRC_W-1:0]   src_q;

    assign pick_ptr = (RR_MODE != 0) ? ptr : '0;

    rr_pick #(.N(NUM_SRC), .PW(SRC_W)) u_pick (
        .req  (bus.req),
        .ptr  (pick_ptr),
        .grant(pol_grant)
    );

`ifdef CDB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0]      wait_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_SRC; i++)
            starved[i] = bus.req[i] && (wait_cnt[i] == CW'(MAX_WAIT));
    end

    // Starved sources preempt the policy; lowest starved index wins.
    assign grant_raw = (|starved) ? (starved & (-starved)) : pol_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!bus.req[i] || grant[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != CW'(MAX_WAIT))
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
            end
        end
    end
`else
    assign grant_raw = pol_grant;
`endif

    assign grant     = rst ? grant_raw : '0;
    assign any_grant = |grant;

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                gidx  = SRC_W'(i);
                gdata = bus.data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            if (any_grant)
                ptr <= (gidx == SRC_W'(NUM_SRC - 1)) ? '0 : gidx + SRC_W'(1);
            valid_q <= any_grant;
            data_q  <= gdata;
            src_q   <= gidx;
        end
    end

    assign bus.grant     = grant;
    assign bus.cdb_valid = valid_q;
    assign bus.cdb_data  = data_q;
    assign bus.cdb_src   = src_q;

    // A waiting source must hold its request until it is granted.
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_hold_chk
            req_hold_a: assert property (@(posedge clk) disable iff (!rst)
                (bus.req[i] && !bus.grant[i]) |=> bus.req[i]);
        end
    endgenerate
endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Bench for cdb_arbiter_rr: one round-robin and one fixed-priority instance,
// expected broadcasts queued at grant time and compared one cycle later.
module tb_cdb_arbiter_rr;
    import cdb_pkg::*;

    typedef struct {
        logic        v;
        logic [2:0]  src;
        logic [39:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   vecs = 0;
    int   errs = 0;
    exp_t sb[$];
    logic [39:0] cur [2][5];

    cdb_arbiter_rr_if #(.NUM_SRC(5), .DATA_W(40)) rr_if ();
    cdb_arbiter_rr_if #(.NUM_SRC(5), .DATA_W(40)) fx_if ();

    cdb_arbiter_rr #(.NUM_SRC(5), .DATA_W(40), .RR_MODE(1), .MAX_WAIT(8)) u_rr (
        .clk(clk), .rst(rst), .bus(rr_if));
    cdb_arbiter_rr #(.NUM_SRC(5), .DATA_W(40), .RR_MODE(0), .MAX_WAIT(8)) u_fx (
        .clk(clk), .rst(rst), .bus(fx_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] onehot(int idx);
        logic [4:0] one;
        one = 5'b00001;
        return (idx < 0) ? 5'b0 : (one << idx);
    endfunction

    function automatic exp_t mk_exp(bit fx, int idx);
        exp_t e;
        e.v = 1'b0; e.src = 3'd0; e.data = '0;
        if (idx >= 0) begin
            e.v = 1'b1; e.src = 3'(idx); e.data = cur[fx][idx];
        end
        return e;
    endfunction

    function automatic logic [4:0] grant_of(bit fx);
        return fx ? fx_if.grant : rr_if.grant;
    endfunction

    // {valid, src, data}
    function automatic logic [43:0] cdb_of(bit fx);
        return fx ? {fx_if.cdb_valid, fx_if.cdb_src, fx_if.cdb_data}
                  : {rr_if.cdb_valid, rr_if.cdb_src, rr_if.cdb_data};
    endfunction

    task automatic set_req(bit fx, int i, logic r);
        if (fx) fx_if.req[i] = r; else rr_if.req[i] = r;
    endtask

    task automatic put_data(bit fx, int i);
        if (fx) fx_if.data_in[i*40 +: 40] = cur[1][i];
        else    rr_if.data_in[i*40 +: 40] = cur[0][i];
    endtask

    task automatic test_reset();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
        int          exp_g[5] = '{0, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            cur[0][i] = {8'(8'hC0 + i), 32'h0000_0100};
            put_data(0, i);
            set_req(0, i, 1'b1);
        end
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if (rr_if.grant !== 5'b0) begin
            errs++; $display("FAIL reset_grant got %b want 00000", rr_if.grant);
        end
        o = cdb_of(0);
        vecs++;
        if (o !== 44'h0) begin
            errs++; $display("FAIL reset_cdb got %h want 0", o);
        end
        vecs++;
        if (fx_if.cdb_valid !== 1'b0) begin
            errs++; $display("FAIL reset_fx_valid got %b want 0", fx_if.cdb_valid);
        end
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1 g = grant_of(0);
            vecs++;
            if (g !== onehot(exp_g[c])) begin
                errs++; $display("FAIL reset_drain_grant c=%0d got %b want %b", c, g, onehot(exp_g[c]));
            end
            sb.push_back(mk_exp(0, exp_g[c]));
            @(posedge clk); #1;
            o = cdb_of(0); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL reset_drain_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            for (int i = 0; i < 5; i++) if (g[i]) set_req(0, i, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
        int          pre_g[2]  = '{0, 1};
        int          post_g[4] = '{0, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            cur[0][i] = {8'(8'hD0 + i), 32'h0000_0200};
            put_data(0, i);
            set_req(0, i, 1'b1);
        end
        for (int c = 0; c < 2; c++) begin
            #1 g = grant_of(0);
            vecs++;
            if (g !== onehot(pre_g[c])) begin
                errs++; $display("FAIL midop_pre_grant c=%0d got %b want %b", c, g, onehot(pre_g[c]));
            end
            sb.push_back(mk_exp(0, pre_g[c]));
            @(posedge clk); #1;
            o = cdb_of(0); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL midop_pre_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            // src 0 keeps requesting with fresh data; others retire
            for (int i = 0; i < 5; i++) if (g[i]) begin
                if (i == 0) begin cur[0][0] = cur[0][0] + 40'd1; put_data(0, 0); end
                else set_req(0, i, 1'b0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        vecs++;
        if (rr_if.grant !== 5'b0 || rr_if.cdb_valid !== 1'b0) begin
            errs++; $display("FAIL midop_async got grant=%b v=%b want 00000 0", rr_if.grant, rr_if.cdb_valid);
        end
        @(posedge clk); #1;
        vecs++;
        if (rr_if.cdb_valid !== 1'b0 || rr_if.cdb_data !== 40'h0) begin
            errs++; $display("FAIL midop_held got v=%b data=%h want 0 0", rr_if.cdb_valid, rr_if.cdb_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 g = grant_of(0);
            vecs++;
            if (g !== onehot(post_g[c])) begin
                errs++; $display("FAIL midop_post_grant c=%0d got %b want %b", c, g, onehot(post_g[c]));
            end
            sb.push_back(mk_exp(0, post_g[c]));
            @(posedge clk); #1;
            o = cdb_of(0); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL midop_post_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            for (int i = 0; i < 5; i++) if (g[i]) set_req(0, i, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_rr_wrap();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
        int          exp_g[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            cur[0][i] = {8'(8'hE0 + i), 32'h0000_0300};
            put_data(0, i);
            set_req(0, i, 1'b1);
        end
        for (int c = 0; c < 10; c++) begin
            #1 g = grant_of(0);
            vecs++;
            if (g !== onehot(exp_g[c])) begin
                errs++; $display("FAIL rr_wrap_grant c=%0d got %b want %b", c, g, onehot(exp_g[c]));
            end
            sb.push_back(mk_exp(0, exp_g[c]));
            @(posedge clk); #1;
            o = cdb_of(0); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL rr_wrap_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            for (int i = 0; i < 5; i++) if (g[i]) begin
                if (c >= 5) set_req(0, i, 1'b0);
                else begin cur[0][i] = cur[0][i] + 40'd1; put_data(0, i); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lone();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
        cur[0][SRC_LS] = 40'hA5_0000_0001;
        put_data(0, SRC_LS);
        set_req(0, SRC_LS, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1 g = grant_of(0);
            vecs++;
            if (g !== onehot(SRC_LS)) begin
                errs++; $display("FAIL lone_grant c=%0d got %b want %b", c, g, onehot(SRC_LS));
            end
            sb.push_back(mk_exp(0, SRC_LS));
            @(posedge clk); #1;
            o = cdb_of(0); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL lone_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            if (g[SRC_LS]) begin
                if (c >= 3) set_req(0, SRC_LS, 1'b0);
                else begin cur[0][SRC_LS] = cur[0][SRC_LS] + 40'd1; put_data(0, SRC_LS); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
        // Pointer sits at 4 after the lone src 3 run; idle cycles must keep it.
        int          exp_g[10] = '{-1, -1, -1, -1, -1, 4, 0, 1, 2, 3};
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                for (int i = 0; i < 5; i++) begin
                    cur[0][i] = {8'(8'hB0 + i), 32'h0000_0400};
                    put_data(0, i);
                    set_req(0, i, 1'b1);
                end
            end
            #1 g = grant_of(0);
            vecs++;
            if (g !== onehot(exp_g[c])) begin
                errs++; $display("FAIL idle_grant c=%0d got %b want %b", c, g, onehot(exp_g[c]));
            end
            sb.push_back(mk_exp(0, exp_g[c]));
            @(posedge clk); #1;
            o = cdb_of(0); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL idle_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            for (int i = 0; i < 5; i++) if (g[i]) set_req(0, i, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_fixed();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
        int          exp_g[4] = '{1, 2, 4, -1};
        for (int i = 0; i < 5; i++) begin
            cur[1][i] = {8'(8'hF0 + i), 32'h0000_0500};
            put_data(1, i);
        end
        fx_if.req = 5'b10110;
        for (int c = 0; c < 4; c++) begin
            #1 g = grant_of(1);
            vecs++;
            if (g !== onehot(exp_g[c])) begin
                errs++; $display("FAIL fixed_grant c=%0d got %b want %b", c, g, onehot(exp_g[c]));
            end
            sb.push_back(mk_exp(1, exp_g[c]));
            @(posedge clk); #1;
            o = cdb_of(1); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL fixed_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            for (int i = 0; i < 5; i++) if (g[i]) set_req(1, i, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_starve();
        logic [4:0]  g;
        logic [43:0] o;
        exp_t        e;
`ifdef CDB_STARVE_GUARD_EN
        // src 4 wins on its 9th waiting cycle, then src 0 resumes
        localparam int NS = 10;
        int exp_g[NS] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 0};
`else
        // pure fixed priority: src 4 waits until src 0 retires
        localparam int NS = 11;
        int exp_g[NS] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};
`endif
        cur[1][SRC_ALU] = 40'h11_0000_0000;
        cur[1][SRC_BR]  = 40'h44_0000_0000;
        put_data(1, SRC_ALU);
        put_data(1, SRC_BR);
        fx_if.req = 5'b10001;
        for (int c = 0; c < NS; c++) begin
            #1 g = grant_of(1);
            vecs++;
            if (g !== onehot(exp_g[c])) begin
                errs++; $display("FAIL starve_grant c=%0d got %b want %b", c, g, onehot(exp_g[c]));
            end
            sb.push_back(mk_exp(1, exp_g[c]));
            @(posedge clk); #1;
            o = cdb_of(1); e = sb.pop_front(); vecs++;
            if (o[43] !== e.v || o[39:0] !== e.data || (e.v && o[42:40] !== e.src)) begin
                errs++;
                $display("FAIL starve_cdb c=%0d got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                         c, o[43], o[42:40], o[39:0], e.v, e.src, e.data);
            end
            if (g[SRC_BR]) set_req(1, SRC_BR, 1'b0);
            if (g[SRC_ALU]) begin
                if (c >= NS - 2) set_req(1, SRC_ALU, 1'b0);
                else begin cur[1][SRC_ALU] = cur[1][SRC_ALU] + 40'd1; put_data(1, SRC_ALU); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0;
        rr_if.req = '0; rr_if.data_in = '0;
        fx_if.req = '0; fx_if.data_in = '0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 5; i++) cur[d][i] = '0;
        @(negedge clk);
        test_reset();
        test_reset_midop();
        test_rr_wrap();
        test_lone();
        test_idle();
        test_fixed();
        test_starve();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter_rr.md
Name: cdb_arbiter_rr

Overview:
- Parametrised common-data-bus arbiter for the Tomasulo core.
- Accepts NUM_SRC functional-unit result requests and broadcasts one result per cycle as a registered {valid, payload} bus to the reservation stations, register status table and ROB.
- Adds two things over a simple fixed-priority bus:
  - a per-source grant handshake, so losing units hold their result instead of dropping it;
  - selectable round-robin or fixed priority.

Parameters:
- NUM_SRC, 5, number of requesting units (index 0 = ALU, 1 = mul, 2 = div, 3 = ld/st, 4 = branch).
- DATA_W, 40, payload width (tag + value), broadcast unchanged.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- MAX_WAIT, 8, starvation threshold in cycles; used only with CDB_STARVE_GUARD_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_SRC  per-source request; must stay high with stable data until granted.
- data_in  in  NUM_SRC*DATA_W  packed payloads; source i occupies bits [i*DATA_W +: DATA_W].
- grant  out  NUM_SRC  combinational one-hot grant, same cycle as req.
- cdb_valid  out  1  registered broadcast valid.
- cdb_data  out  DATA_W  registered broadcast payload.
- cdb_src  out  $clog2(NUM_SRC)  registered index of the broadcasting source.

Behaviour:
- Reset (rst low, asynchronous):
  - cdb_valid=0, cdb_data=0, cdb_src=0.
  - RR pointer=0; all wait counters=0.
  - grant is forced to 0 while rst is low.
- Grant:
  - At most one grant bit is high per cycle.
  - grant=0 when req=0.
  - A source drops req, or presents new data, only in the cycle after it sees grant.
- Fixed mode: grant goes to the lowest-index requester.
- Round-robin mode:
  - Search starts at pointer p and proceeds p, p+1, ... NUM_SRC-1, 0, ... p-1; first requester wins.
  - On any grant to index g, p becomes (g+1) mod NUM_SRC at the clock edge, wrapping from NUM_SRC-1 to 0.
  - With no grant, p holds.
- Broadcast: latency 1 cycle. At the edge following a grant to g: cdb_valid=1, cdb_data=data_in[g], cdb_src=g. With no grant: cdb_valid=0 and cdb_data=0 (zeroed, not held).
- Throughput: one broadcast per cycle. Back-to-back grants to the same source are allowed in fixed mode, or in RR mode when it is the only requester.
- No backpressure: the bus never stalls.
- Reset mid-operation: any pending grant is abandoned. The source keeps req high and is re-arbitrated after reset deasserts.
- Req glitch: a req that drops without a grant is a protocol violation. A simulation assertion flags it; the RTL takes no action.

Optional Feature:
- CDB_STARVE_GUARD_EN defined:
  - Each source has a saturating counter of width $clog2(MAX_WAIT+1). It increments while req is high and grant is low, and clears on grant or when req is low.
  - Any source whose counter reaches MAX_WAIT overrides the normal policy.
  - If several sources reach MAX_WAIT together, the lowest index among them wins.
  - The RR pointer still updates from the actual grant.
- Not defined: no counters are instantiated and arbitration is purely by RR_MODE.

Decomposition:
- Shared package cdb_pkg holds:
  - CDB_DATA_W=40;
  - source index constants SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_LS=3, SRC_BR=4;
  - CDB_NUM_SRC=5;
  - the typedef of the {valid, payload} bus word.
- One natural sub-module, rr_pick: combinational rotate-and-find-first. Inputs are req and pointer; output is the one-hot grant. With pointer tied to 0 it also serves fixed mode.
- The top level holds the pointer, the starvation counters, the output register and the data mux.

Test Plan:
- Reset: hold rst=0 with req=5'b11111 → grant=0 and cdb_valid=0. Release rst → next edge gives cdb_valid=1, cdb_src=0.
- Fixed mode (RR_MODE=0): req=5'b10110 held for 3 cycles, sources dropping their own req after grant → grants 1, then 2, then 4. cdb_src sequence is 1, 2, 4, each one cycle after its grant.
- Round-robin: req=5'b11111 held continuously → cdb_src sequence 0, 1, 2, 3, 4, 0, with pointer wrap verified at 4→0.
- Lone requester: only src 3 requests for 4 cycles with data 40'hA5_0000_0001 incrementing → 4 consecutive broadcasts; cdb_data matches each value in order, 1-cycle latency.
- Starvation (macro on, RR_MODE=0, MAX_WAIT=8): src 0 requests continuously and src 4 requests continuously → src 4 granted on exactly its 9th cycle of waiting, then src 0 resumes.
- Idle: req=0 for 5 cycles after activity → cdb_valid=0, cdb_data=0, and the pointer is unchanged (checked by the next grant order).
